// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with a 16-state TMS-driven FSM and Moore-decoded IR/DR strobes.
// Defining TAP_STATE_OUT_EN adds the o_state[3:0] debug port.
module tap_controller (
   input  logic       i_tck,
   input  logic       i_reset,
   input  logic       i_tms,
   output logic       o_test_reset,
   output logic       o_shift_ir,
   output logic       o_clock_ir,
   output logic       o_update_ir,
   output logic       o_shift_dr,
   output logic       o_clock_dr,
   output logic       o_update_dr,
   output logic       o_select,
   output logic       o_enable
`ifdef TAP_STATE_OUT_EN
   ,
   output logic [3:0] o_state
`endif
);

   // state    | meaning
   // TLR   F  | test-logic reset
   // RTI   C  | run-test/idle
   // SEL_DR 7 | select-DR-scan
   // CAP_DR 6 | capture-DR
   // SH_DR  2 | shift-DR
   // EX1_DR 1 | exit1-DR
   // PAU_DR 3 | pause-DR
   // EX2_DR 0 | exit2-DR
   // UPD_DR 5 | update-DR
   // SEL_IR 4 ... UPD_IR D | IR column, mirrors DR column
   typedef enum logic [3:0] {
      TLR    = 4'hF,
      RTI    = 4'hC,
      SEL_DR = 4'h7,
      CAP_DR = 4'h6,
      SH_DR  = 4'h2,
      EX1_DR = 4'h1,
      PAU_DR = 4'h3,
      EX2_DR = 4'h0,
      UPD_DR = 4'h5,
      SEL_IR = 4'h4,
      CAP_IR = 4'hE,
      SH_IR  = 4'hA,
      EX1_IR = 4'h9,
      PAU_IR = 4'hB,
      EX2_IR = 4'h8,
      UPD_IR = 4'hD
   } state_t;

   state_t r_state;
   state_t w_next;

   always_ff @(posedge i_tck) begin
      if (i_reset) r_state <= TLR;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         TLR:    w_next = i_tms ? TLR    : RTI;
         RTI:    w_next = i_tms ? SEL_DR : RTI;
         SEL_DR: w_next = i_tms ? SEL_IR : CAP_DR;
         CAP_DR: w_next = i_tms ? EX1_DR : SH_DR;
         SH_DR:  w_next = i_tms ? EX1_DR : SH_DR;
         EX1_DR: w_next = i_tms ? UPD_DR : PAU_DR;
         PAU_DR: w_next = i_tms ? EX2_DR : PAU_DR;
         EX2_DR: w_next = i_tms ? UPD_DR : SH_DR;
         UPD_DR: w_next = i_tms ? SEL_DR : RTI;
         SEL_IR: w_next = i_tms ? TLR    : CAP_IR;
         CAP_IR: w_next = i_tms ? EX1_IR : SH_IR;
         SH_IR:  w_next = i_tms ? EX1_IR : SH_IR;
         EX1_IR: w_next = i_tms ? UPD_IR : PAU_IR;
         PAU_IR: w_next = i_tms ? EX2_IR : PAU_IR;
         EX2_IR: w_next = i_tms ? UPD_IR : SH_IR;
         UPD_IR: w_next = i_tms ? SEL_DR : RTI;
         default: w_next = TLR;
      endcase
   end

   // Pure Moore decode: no TMS term, so strobes are stable for the whole cycle.
   always_comb begin
      o_test_reset = 1'b0;
      o_shift_ir   = 1'b0;
      o_clock_ir   = 1'b0;
      o_update_ir  = 1'b0;
      o_shift_dr   = 1'b0;
      o_clock_dr   = 1'b0;
      o_update_dr  = 1'b0;
      o_select     = 1'b0;
      o_enable     = 1'b0;
      case (r_state)
         TLR:    o_test_reset = 1'b1;
         CAP_DR: o_clock_dr   = 1'b1;
         SH_DR: begin
            o_shift_dr = 1'b1;
            o_clock_dr = 1'b1;
            o_enable   = 1'b1;
         end
         UPD_DR: o_update_dr  = 1'b1;
         CAP_IR: begin
            o_clock_ir = 1'b1;
            o_select   = 1'b1;
         end
         SH_IR: begin
            o_shift_ir = 1'b1;
            o_clock_ir = 1'b1;
            o_enable   = 1'b1;
            o_select   = 1'b1;
         end
         UPD_IR: begin
            o_update_ir = 1'b1;
            o_select    = 1'b1;
         end
         SEL_IR, EX1_IR, PAU_IR, EX2_IR: o_select = 1'b1;
         default: ;
      endcase
   end

`ifdef TAP_STATE_OUT_EN
   assign o_state = r_state;
`endif

endmodule

// File: tb/tb_tap_controller.sv
// Table-driven bench for tap_controller: per-edge state/strobe vectors plus strobe-count scans.
// Checks o_state only when built with TAP_STATE_OUT_EN.
module tb_tap_controller;

   logic       clk;
   logic       rst;
   logic       tms;
   logic       test_reset, shift_ir, clock_ir, update_ir;
   logic       shift_dr, clock_dr, update_dr, sel, en;
`ifdef TAP_STATE_OUT_EN
   logic [3:0] state;
`endif

   tap_controller dut (
      .i_tck        (clk),
      .i_reset      (rst),
      .i_tms        (tms),
      .o_test_reset (test_reset),
      .o_shift_ir   (shift_ir),
      .o_clock_ir   (clock_ir),
      .o_update_ir  (update_ir),
      .o_shift_dr   (shift_dr),
      .o_clock_dr   (clock_dr),
      .o_update_dr  (update_dr),
      .o_select     (sel),
      .o_enable     (en)
`ifdef TAP_STATE_OUT_EN
      ,
      .o_state      (state)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {test_reset, select, enable, shift_ir, clock_ir, update_ir, shift_dr, clock_dr, update_dr}
   localparam logic [8:0] O_TLR   = 9'b100000000;
   localparam logic [8:0] O_NONE  = 9'b000000000;
   localparam logic [8:0] O_CAPDR = 9'b000000010;
   localparam logic [8:0] O_SHDR  = 9'b001000110;
   localparam logic [8:0] O_UPDDR = 9'b000000001;
   localparam logic [8:0] O_IRCOL = 9'b010000000;
   localparam logic [8:0] O_CAPIR = 9'b010010000;
   localparam logic [8:0] O_SHIR  = 9'b011110000;
   localparam logic [8:0] O_UPDIR = 9'b010001000;

   typedef struct {
      logic       rst;
      logic       tms;
      logic [3:0] st;
      logic [8:0] out;
   } vec_t;

   vec_t vecs[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic logic [8:0] outs();
      return {test_reset, sel, en, shift_ir, clock_ir, update_ir, shift_dr, clock_dr, update_dr};
   endfunction

   task automatic add(input logic r, input logic t, input logic [3:0] s, input logic [8:0] o);
      vec_t v;
      v.rst = r; v.tms = t; v.st = s; v.out = o;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step(input logic r, input logic t);
      @(negedge clk);
      rst = r;
      tms = t;
      @(posedge clk);
      #1;
   endtask

   bit ir_seq [9]  = '{1, 1, 0, 0, 0, 0, 1, 1, 0};
   bit dr_seq [10] = '{1, 0, 0, 1, 0, 0, 1, 0, 1, 1};

   initial begin
      int c_clk, c_sh, c_en, c_upd, c_sel;
      rst = 1'b0;
      tms = 1'b0;

      // reset and release
      add(1, 0, 4'hF, O_TLR);
      add(0, 0, 4'hC, O_NONE);
      add(0, 0, 4'hC, O_NONE);
      // IR scan
      add(0, 1, 4'h7, O_NONE);
      add(0, 1, 4'h4, O_IRCOL);
      add(0, 0, 4'hE, O_CAPIR);
      add(0, 0, 4'hA, O_SHIR);
      add(0, 0, 4'hA, O_SHIR);
      add(0, 0, 4'hA, O_SHIR);
      add(0, 1, 4'h9, O_IRCOL);
      add(0, 1, 4'hD, O_UPDIR);
      add(0, 0, 4'hC, O_NONE);
      // DR scan with pause
      add(0, 1, 4'h7, O_NONE);
      add(0, 0, 4'h6, O_CAPDR);
      add(0, 0, 4'h2, O_SHDR);
      add(0, 1, 4'h1, O_NONE);
      add(0, 0, 4'h3, O_NONE);
      add(0, 0, 4'h3, O_NONE);
      add(0, 1, 4'h0, O_NONE);
      add(0, 0, 4'h2, O_SHDR);
      add(0, 1, 4'h1, O_NONE);
      add(0, 1, 4'h5, O_UPDDR);
      // back to Shift-DR, then TMS=1 x6
      add(0, 1, 4'h7, O_NONE);
      add(0, 0, 4'h6, O_CAPDR);
      add(0, 0, 4'h2, O_SHDR);
      add(0, 1, 4'h1, O_NONE);
      add(0, 1, 4'h5, O_UPDDR);
      add(0, 1, 4'h7, O_NONE);
      add(0, 1, 4'h4, O_IRCOL);
      add(0, 1, 4'hF, O_TLR);
      add(0, 1, 4'hF, O_TLR);
      // reset while in Shift-IR
      add(0, 0, 4'hC, O_NONE);
      add(0, 1, 4'h7, O_NONE);
      add(0, 1, 4'h4, O_IRCOL);
      add(0, 0, 4'hE, O_CAPIR);
      add(0, 0, 4'hA, O_SHIR);
      add(1, 0, 4'hF, O_TLR);
      // reset with TMS=1 while in Pause-DR
      add(0, 0, 4'hC, O_NONE);
      add(0, 1, 4'h7, O_NONE);
      add(0, 0, 4'h6, O_CAPDR);
      add(0, 1, 4'h1, O_NONE);
      add(0, 0, 4'h3, O_NONE);
      add(1, 1, 4'hF, O_TLR);
      // IR pause/exit2 loop and Update-IR -> Select-DR
      add(0, 0, 4'hC, O_NONE);
      add(0, 1, 4'h7, O_NONE);
      add(0, 1, 4'h4, O_IRCOL);
      add(0, 0, 4'hE, O_CAPIR);
      add(0, 1, 4'h9, O_IRCOL);
      add(0, 0, 4'hB, O_IRCOL);
      add(0, 0, 4'hB, O_IRCOL);
      add(0, 1, 4'h8, O_IRCOL);
      add(0, 0, 4'hA, O_SHIR);
      add(0, 1, 4'h9, O_IRCOL);
      add(0, 1, 4'hD, O_UPDIR);
      add(0, 1, 4'h7, O_NONE);
      add(0, 1, 4'h4, O_IRCOL);
      add(0, 1, 4'hF, O_TLR);
      // Exit2-DR -> Update-DR and Update-DR -> RTI
      add(0, 0, 4'hC, O_NONE);
      add(0, 1, 4'h7, O_NONE);
      add(0, 0, 4'h6, O_CAPDR);
      add(0, 0, 4'h2, O_SHDR);
      add(0, 1, 4'h1, O_NONE);
      add(0, 0, 4'h3, O_NONE);
      add(0, 1, 4'h0, O_NONE);
      add(0, 1, 4'h5, O_UPDDR);
      add(0, 0, 4'hC, O_NONE);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].tms);
         check($sformatf("vec%0d outputs", i), int'(outs()), int'(vecs[i].out));
`ifdef TAP_STATE_OUT_EN
         check($sformatf("vec%0d state", i), int'(state), int'(vecs[i].st));
`endif
      end

      // IR scan strobe widths
      step(1, 0);
      step(0, 0);
      c_clk = 0; c_sh = 0; c_en = 0; c_upd = 0; c_sel = 0;
      for (int i = 0; i < 9; i++) begin
         step(0, ir_seq[i]);
         c_clk += int'(clock_ir);
         c_sh  += int'(shift_ir);
         c_en  += int'(en);
         c_upd += int'(update_ir);
         c_sel += int'(sel);
      end
      check("ir ClockIR cycles",  c_clk, 4);
      check("ir ShiftIR cycles",  c_sh,  3);
      check("ir Enable cycles",   c_en,  3);
      check("ir UpdateIR cycles", c_upd, 1);
      check("ir Select cycles",   c_sel, 7);

      // DR scan strobe widths
      c_clk = 0; c_sh = 0; c_en = 0; c_upd = 0; c_sel = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, dr_seq[i]);
         c_clk += int'(clock_dr);
         c_sh  += int'(shift_dr);
         c_en  += int'(en);
         c_upd += int'(update_dr);
         c_sel += int'(sel);
      end
      check("dr ClockDR cycles",  c_clk, 3);
      check("dr ShiftDR cycles",  c_sh,  2);
      check("dr Enable cycles",   c_en,  2);
      check("dr UpdateDR cycles", c_upd, 1);
      check("dr Select cycles",   c_sel, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
